// File: rtl/msdap_ctrl.sv
// MSDAP main sequencing controller: memory init, Rj/coeff load, sample processing, clear and sleep.
// Optional sleep mode (zero counter + SLEEPING state) is enabled by defining MSDAP_SLEEP_EN.
//
// state | meaning
// ------+--------------------------------------------------
//   0   | INIT       data-memory clear sweep after reset/start
//   1   | WAIT_RJ    waiting for first Rj word
//   2   | READ_RJ    loading remaining Rj words
//   3   | WAIT_COEFF waiting for first coefficient word
//   4   | READ_COEFF loading remaining coefficient words
//   5   | WAIT_DATA  waiting for first sample (written at address 0)
//   6   | WORKING    circular sample writes + compute trigger
//   7   | CLEARING   data-memory clear sweep, then WAIT_DATA
//   8   | SLEEPING   zero samples discarded until a nonzero one arrives
module msdap_ctrl #(
    parameter int RJ_COUNT    = 16,
    parameter int COEFF_COUNT = 512,
    parameter int DATA_DEPTH  = 256,
    parameter int SLEEP_COUNT = 800,
    parameter int ADDR_W      = 9
) (
    input  logic              sclk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear_req,
    input  logic              word_valid,
    input  logic [15:0]       word_L,
    input  logic [15:0]       word_R,
    input  logic              compute_busy,
    output logic              in_ready,
    output logic              mem_we,
    output logic [1:0]        mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_clr,
    output logic              compute_start,
    output logic [ADDR_W-1:0] data_ptr,
    output logic              sleep,
    output logic              overrun,
    output logic [3:0]        state
);

    localparam logic [3:0] S_INIT       = 4'd0;
    localparam logic [3:0] S_WAIT_RJ    = 4'd1;
    localparam logic [3:0] S_READ_RJ    = 4'd2;
    localparam logic [3:0] S_WAIT_COEFF = 4'd3;
    localparam logic [3:0] S_READ_COEFF = 4'd4;
    localparam logic [3:0] S_WAIT_DATA  = 4'd5;
    localparam logic [3:0] S_WORKING    = 4'd6;
    localparam logic [3:0] S_CLEARING   = 4'd7;
    localparam logic [3:0] S_SLEEPING   = 4'd8;

    localparam logic [1:0] SEL_RJ    = 2'd0;
    localparam logic [1:0] SEL_COEFF = 2'd1;
    localparam logic [1:0] SEL_DATA  = 2'd2;

    localparam logic [ADDR_W-1:0] DEPTH_LAST = ADDR_W'(DATA_DEPTH - 1);
    localparam logic [ADDR_W-1:0] RJ_LAST    = ADDR_W'(RJ_COUNT - 1);
    localparam logic [ADDR_W-1:0] COEFF_LAST = ADDR_W'(COEFF_COUNT - 1);

    logic [3:0]        state_n;
    logic [ADDR_W-1:0] sweep_cnt, sweep_cnt_n;
    logic              sweep_last, sweep_last_n;
    logic [ADDR_W-1:0] ld_cnt, ld_cnt_n;
    logic [ADDR_W-1:0] ptr_n, ptr_inc;
    logic              we_n, clr_n, cs_n, ovr_n, cs_pipe;
    logic [1:0]        sel_n;
    logic [ADDR_W-1:0] addr_n;
    logic              accept, word_zero, discard;

    assign accept    = word_valid && in_ready;
    assign word_zero = (word_L == 16'd0) && (word_R == 16'd0);
    assign ptr_inc   = (data_ptr + ADDR_W'(1)) & DEPTH_LAST;
    // SLEEPING is never entered without the sleep feature, so this term is inert there.
    assign discard   = (state == S_SLEEPING) && word_zero;

`ifdef MSDAP_SLEEP_EN
    localparam int ZC_W = $clog2(SLEEP_COUNT + 1);
    localparam logic [ZC_W-1:0] ZC_MAX = ZC_W'(SLEEP_COUNT);
    logic [ZC_W-1:0] zero_cnt, zero_cnt_n;
`endif

    always_comb begin
        state_n      = state;
        sweep_cnt_n  = sweep_cnt;
        sweep_last_n = sweep_last;
        ld_cnt_n     = ld_cnt;
        ptr_n        = data_ptr;
        we_n         = 1'b0;
        clr_n        = 1'b0;
        sel_n        = SEL_RJ;
        addr_n       = '0;
        cs_n         = 1'b0;
        ovr_n        = overrun;
`ifdef MSDAP_SLEEP_EN
        zero_cnt_n   = zero_cnt;
`endif
        if (start) begin
            state_n      = S_INIT;
            sweep_cnt_n  = '0;
            sweep_last_n = 1'b0;
            ld_cnt_n     = '0;
            ptr_n        = '0;
            ovr_n        = 1'b0;
`ifdef MSDAP_SLEEP_EN
            zero_cnt_n   = '0;
`endif
        end else begin
            case (state)
                S_INIT, S_CLEARING: begin
                    if (sweep_last) begin
                        state_n      = (state == S_INIT) ? S_WAIT_RJ : S_WAIT_DATA;
                        sweep_cnt_n  = '0;
                        sweep_last_n = 1'b0;
                    end else begin
                        we_n         = 1'b1;
                        clr_n        = 1'b1;
                        sel_n        = SEL_DATA;
                        addr_n       = sweep_cnt;
                        sweep_cnt_n  = sweep_cnt + ADDR_W'(1);
                        sweep_last_n = (sweep_cnt == DEPTH_LAST);
                    end
                end
                S_WAIT_RJ, S_READ_RJ: begin
                    if (accept) begin
                        we_n   = 1'b1;
                        sel_n  = SEL_RJ;
                        addr_n = ld_cnt;
                        if (ld_cnt == RJ_LAST) begin
                            state_n  = S_WAIT_COEFF;
                            ld_cnt_n = '0;
                        end else begin
                            state_n  = S_READ_RJ;
                            ld_cnt_n = ld_cnt + ADDR_W'(1);
                        end
                    end
                end
                S_WAIT_COEFF, S_READ_COEFF: begin
                    if (accept) begin
                        we_n   = 1'b1;
                        sel_n  = SEL_COEFF;
                        addr_n = ld_cnt;
                        if (ld_cnt == COEFF_LAST) begin
                            state_n  = S_WAIT_DATA;
                            ld_cnt_n = '0;
                        end else begin
                            state_n  = S_READ_COEFF;
                            ld_cnt_n = ld_cnt + ADDR_W'(1);
                        end
                    end
                end
                S_WAIT_DATA, S_WORKING, S_SLEEPING: begin
                    if (clear_req) begin
                        state_n = S_CLEARING;
                        ptr_n   = '0;
`ifdef MSDAP_SLEEP_EN
                        zero_cnt_n = '0;
`endif
                    end else if (accept && !discard) begin
                        ptr_n   = (state == S_WAIT_DATA) ? '0 : ptr_inc;
                        we_n    = 1'b1;
                        sel_n   = SEL_DATA;
                        addr_n  = ptr_n;
                        cs_n    = 1'b1;
                        state_n = S_WORKING;
                        if ((state != S_WAIT_DATA) && compute_busy)
                            ovr_n = 1'b1;
`ifdef MSDAP_SLEEP_EN
                        if (!word_zero)
                            zero_cnt_n = '0;
                        else if (zero_cnt != ZC_MAX)
                            zero_cnt_n = zero_cnt + ZC_W'(1);
                        if (word_zero && (zero_cnt_n == ZC_MAX))
                            state_n = S_SLEEPING;
`endif
                    end
                end
                default: state_n = S_INIT;
            endcase
        end
    end

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            state         <= S_INIT;
            in_ready      <= 1'b0;
            mem_we        <= 1'b0;
            mem_sel       <= SEL_RJ;
            mem_addr      <= '0;
            mem_clr       <= 1'b0;
            cs_pipe       <= 1'b0;
            compute_start <= 1'b0;
            data_ptr      <= '0;
            overrun       <= 1'b0;
            sweep_cnt     <= '0;
            sweep_last    <= 1'b0;
            ld_cnt        <= '0;
        end else begin
            state         <= state_n;
            in_ready      <= (state_n != S_INIT) && (state_n != S_CLEARING);
            mem_we        <= we_n;
            mem_sel       <= sel_n;
            mem_addr      <= addr_n;
            mem_clr       <= clr_n;
            cs_pipe       <= cs_n;
            compute_start <= cs_pipe && !start;
            data_ptr      <= ptr_n;
            overrun       <= ovr_n;
            sweep_cnt     <= sweep_cnt_n;
            sweep_last    <= sweep_last_n;
            ld_cnt        <= ld_cnt_n;
        end
    end

`ifdef MSDAP_SLEEP_EN
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            zero_cnt <= '0;
            sleep    <= 1'b0;
        end else begin
            zero_cnt <= zero_cnt_n;
            sleep    <= (state_n == S_SLEEPING);
        end
    end
`else
    assign sleep = 1'b0;
`endif

endmodule

// File: tb/tb_msdap_ctrl.sv
// Self-checking bench for msdap_ctrl: load sequence, sample stream, clear, sleep, overrun, resets.
module tb_msdap_ctrl;

    logic        sclk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        clear_req = 1'b0;
    logic        word_valid = 1'b0;
    logic [15:0] word_L = 16'd0;
    logic [15:0] word_R = 16'd0;
    logic        compute_busy = 1'b0;
    logic        in_ready, mem_we, mem_clr, compute_start, sleep, overrun;
    logic [1:0]  mem_sel;
    logic [8:0]  mem_addr, data_ptr;
    logic [3:0]  state;

    int n_chk  = 0;
    int n_pass = 0;

    msdap_ctrl dut (
        .sclk(sclk), .reset(reset), .start(start), .clear_req(clear_req),
        .word_valid(word_valid), .word_L(word_L), .word_R(word_R),
        .compute_busy(compute_busy), .in_ready(in_ready), .mem_we(mem_we),
        .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_clr(mem_clr),
        .compute_start(compute_start), .data_ptr(data_ptr), .sleep(sleep),
        .overrun(overrun), .state(state)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        logic       v;
        logic [15:0] l;
        logic [15:0] r;
        logic       e_we;
        logic [8:0] e_addr;
        logic [8:0] e_ptr;
        logic       e_cs;
        logic [3:0] e_st;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_state"}, 32'(state), 32'd0);
        check({nm, "_in_ready"}, 32'(in_ready), 32'd0);
        check({nm, "_mem_we"}, 32'(mem_we), 32'd0);
        check({nm, "_mem_sel"}, 32'(mem_sel), 32'd0);
        check({nm, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({nm, "_mem_clr"}, 32'(mem_clr), 32'd0);
        check({nm, "_compute_start"}, 32'(compute_start), 32'd0);
        check({nm, "_data_ptr"}, 32'(data_ptr), 32'd0);
        check({nm, "_sleep"}, 32'(sleep), 32'd0);
        check({nm, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    // Run a clear sweep; words and clear requests poked mid-sweep must be ignored.
    task automatic run_sweep(input logic [3:0] next_st, input string nm);
        int n = 0;
        int bad = 0;
        int cyc = 0;
        while (state != next_st && cyc < 1000) begin
            word_valid = (cyc == 3 || cyc == 100);
            clear_req  = (cyc == 3 || cyc == 100);
            word_L     = 16'hFFFF;
            tick();
            if (mem_we) begin
                if (!(mem_clr && mem_sel == 2'd2 && mem_addr == 9'(n))) bad++;
                n++;
            end
            cyc++;
        end
        word_valid = 1'b0;
        clear_req  = 1'b0;
        check({nm, "_reached_state"}, 32'(state), 32'(next_st));
        check({nm, "_clear_cycles"}, 32'(n), 32'd256);
        check({nm, "_bad_clear_writes"}, 32'(bad), 32'd0);
        check({nm, "_in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    task automatic send_load(input logic [15:0] l, input logic [1:0] e_sel,
                             input logic [8:0] e_addr, input logic [3:0] e_st, input string nm);
        word_valid = 1'b1;
        word_L     = l;
        word_R     = ~l;
        tick();
        word_valid = 1'b0;
        check({nm, "_we"}, 32'(mem_we), 32'd1);
        check({nm, "_sel"}, 32'(mem_sel), 32'(e_sel));
        check({nm, "_addr"}, 32'(mem_addr), 32'(e_addr));
        check({nm, "_clr"}, 32'(mem_clr), 32'd0);
        check({nm, "_state"}, 32'(state), 32'(e_st));
        tick();
        check({nm, "_we_one_cycle"}, 32'(mem_we), 32'd0);
    endtask

    task automatic send_sample(input logic [15:0] l, input logic [15:0] r, input logic e_wr,
                               input logic [8:0] e_ptr, input string nm);
        word_valid = 1'b1;
        word_L     = l;
        word_R     = r;
        tick();
        word_valid = 1'b0;
        check({nm, "_we"}, 32'(mem_we), 32'(e_wr));
        if (e_wr) begin
            check({nm, "_sel"}, 32'(mem_sel), 32'd2);
            check({nm, "_addr"}, 32'(mem_addr), 32'(e_ptr));
        end
        check({nm, "_ptr"}, 32'(data_ptr), 32'(e_ptr));
        check({nm, "_cs_early"}, 32'(compute_start), 32'd0);
        tick();
        check({nm, "_cs"}, 32'(compute_start), 32'(e_wr));
        check({nm, "_we_after"}, 32'(mem_we), 32'd0);
    endtask

    initial begin
        int p;
        logic [8:0] e_wake;

        tbl[0] = '{1'b1, 16'h0005, 16'h0000, 1'b1, 9'd0, 9'd0, 1'b0, 4'd6};
        tbl[1] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 9'd0, 9'd0, 1'b1, 4'd6};
        tbl[2] = '{1'b1, 16'h0000, 16'h0000, 1'b1, 9'd1, 9'd1, 1'b0, 4'd6};
        tbl[3] = '{1'b1, 16'h1234, 16'hABCD, 1'b1, 9'd2, 9'd2, 1'b1, 4'd6};
        tbl[4] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 9'd0, 9'd2, 1'b1, 4'd6};
        tbl[5] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 9'd0, 9'd2, 1'b0, 4'd6};

        #2;
        check_zero("reset");
        tick();
        tick();
        reset = 1'b1;
        run_sweep(4'd1, "init_sweep");

        for (int i = 0; i < 16; i++)
            send_load(16'(i + 1), 2'd0, 9'(i), (i == 15) ? 4'd3 : 4'd2, $sformatf("rj%0d", i));
        for (int i = 0; i < 512; i++)
            send_load(16'(i + 100), 2'd1, 9'(i), (i == 511) ? 4'd5 : 4'd4, $sformatf("co%0d", i));
        check("wait_data_ptr", 32'(data_ptr), 32'd0);

        for (int i = 0; i < 6; i++) begin
            word_valid = tbl[i].v;
            word_L     = tbl[i].l;
            word_R     = tbl[i].r;
            tick();
            word_valid = 1'b0;
            check($sformatf("tbl%0d_we", i), 32'(mem_we), 32'(tbl[i].e_we));
            if (tbl[i].e_we) begin
                check($sformatf("tbl%0d_sel", i), 32'(mem_sel), 32'd2);
                check($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
            end
            check($sformatf("tbl%0d_ptr", i), 32'(data_ptr), 32'(tbl[i].e_ptr));
            check($sformatf("tbl%0d_cs", i), 32'(compute_start), 32'(tbl[i].e_cs));
            check($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].e_st));
        end

        for (int s = 4; s <= 300; s++)
            send_sample(16'(s), 16'h0000, 1'b1, 9'((s - 1) % 256), $sformatf("smp%0d", s));
        check("last_ptr", 32'(data_ptr), 32'd43);

        clear_req  = 1'b1;
        word_valid = 1'b1;
        word_L     = 16'h0055;
        tick();
        clear_req  = 1'b0;
        word_valid = 1'b0;
        check("clr_state", 32'(state), 32'd7);
        check("clr_word_dropped", 32'(mem_we), 32'd0);
        check("clr_in_ready", 32'(in_ready), 32'd0);
        run_sweep(4'd5, "clr_sweep");
        check("clr_ptr", 32'(data_ptr), 32'd0);

        send_sample(16'h0001, 16'h0000, 1'b1, 9'd0, "sl_first");
        for (int z = 1; z <= 800; z++) begin
            send_sample(16'h0000, 16'h0000, 1'b1, 9'(z % 256), $sformatf("zero%0d", z));
            if (z == 799) check("zero799_state", 32'(state), 32'd6);
        end
`ifdef MSDAP_SLEEP_EN
        check("sleep_state", 32'(state), 32'd8);
        check("sleep_flag", 32'(sleep), 32'd1);
        for (int z = 1; z <= 10; z++)
            send_sample(16'h0000, 16'h0000, 1'b0, 9'd32, $sformatf("slzero%0d", z));
        e_wake = 9'd33;
`else
        check("nosleep_state", 32'(state), 32'd6);
        check("nosleep_flag", 32'(sleep), 32'd0);
        for (int z = 1; z <= 10; z++)
            send_sample(16'h0000, 16'h0000, 1'b1, 9'((800 + z) % 256), $sformatf("slzero%0d", z));
        e_wake = 9'd43;
`endif
        send_sample(16'h0001, 16'h0000, 1'b1, e_wake, "wake");
        check("wake_state", 32'(state), 32'd6);
        check("wake_sleep", 32'(sleep), 32'd0);

        p = int'(e_wake);
        check("ovr_initial", 32'(overrun), 32'd0);
        compute_busy = 1'b1;
        send_sample(16'h0002, 16'h0000, 1'b1, 9'((p + 1) % 256), "ovr_hit");
        compute_busy = 1'b0;
        check("ovr_set", 32'(overrun), 32'd1);
        send_sample(16'h0003, 16'h0000, 1'b1, 9'((p + 2) % 256), "ovr_next");
        check("ovr_sticky", 32'(overrun), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_state", 32'(state), 32'd0);
        check("start_ovr", 32'(overrun), 32'd0);
        check("start_ptr", 32'(data_ptr), 32'd0);
        check("start_in_ready", 32'(in_ready), 32'd0);
        run_sweep(4'd1, "start_sweep");

        for (int i = 0; i < 16; i++)
            send_load(16'(i + 7), 2'd0, 9'(i), (i == 15) ? 4'd3 : 4'd2, $sformatf("rj2_%0d", i));
        for (int i = 0; i < 5; i++)
            send_load(16'(i + 9), 2'd1, 9'(i), 4'd4, $sformatf("co2_%0d", i));
        word_valid = 1'b1;
        word_L     = 16'h00AA;
        tick();
        word_valid = 1'b0;
        check("pre_rst_we", 32'(mem_we), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_zero("async_rst");
        tick();
        reset = 1'b1;
        run_sweep(4'd1, "rst_sweep");
        send_load(16'h0042, 2'd0, 9'd0, 4'd2, "rj_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/msdap_ctrl.md
# msdap_ctrl

Main sequencing controller for the MSDAP datapath, in the `sclk` domain. It receives word strobes from the serial-input shifter, already synchronized and assembled from the `dclk` domain. It steps the chip through memory initialization, Rj load, coefficient load and sample processing, with clear and sleep modes. It produces the memory write controls, the clear sweeps and the per-sample compute trigger for the filter engine.

## Interface
Parameters:
- `RJ_COUNT`, 16, number of Rj words loaded after init.
- `COEFF_COUNT`, 512, number of coefficient words loaded after Rj.
- `DATA_DEPTH`, 256, depth of the circular sample memory (power of 2).
- `SLEEP_COUNT`, 800, number of consecutive all-zero samples that causes sleep.
- `ADDR_W`, 9, memory address width; must satisfy 2^ADDR_W ≥ max(COEFF_COUNT, DATA_DEPTH).

Ports:
- `sclk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: synchronous restart pulse.
- `clear_req` in 1: synchronized in-band clear request (one-cycle pulse).
- `word_valid` in 1: one-cycle strobe when a new L/R word pair is available.
- `word_L` in 16: left word; sampled only when `word_valid`=1.
- `word_R` in 16: right word; sampled only when `word_valid`=1.
- `compute_busy` in 1: filter engine busy.
- `in_ready` out 1: controller accepts words.
- `mem_we` out 1: write strobe for the selected memory.
- `mem_sel` out 2: selected memory; 0=Rj, 1=coeff, 2=data.
- `mem_addr` out ADDR_W: write or clear address.
- `mem_clr` out 1: write zero instead of the word (used during clear sweeps).
- `compute_start` out 1: one-cycle trigger for a filter pass.
- `data_ptr` out ADDR_W: address of the newest sample.
- `sleep` out 1: sleep mode indicator.
- `overrun` out 1: sticky error flag.
- `state` out 4: current state encoding, for debug.

## Operation
Word acceptance:
- A word is accepted only when `word_valid`=1 and `in_ready`=1.
- Words strobed while `in_ready`=0 are dropped.

State encodings and behaviour:
- INIT (0):
  - Clear sweep of the data memory: `mem_sel`=2, `mem_clr`=1, `mem_we`=1.
  - `mem_addr` runs 0..DATA_DEPTH-1, one address per cycle.
  - When the sweep completes, go to WAIT_RJ.
- WAIT_RJ (1), `in_ready`=1:
  - An accepted word is written to Rj address 0; go to READ_RJ.
- READ_RJ (2):
  - Each accepted word is written to the next Rj address.
  - After the write to address RJ_COUNT-1, go to WAIT_COEFF.
- WAIT_COEFF (3) and READ_COEFF (4):
  - Same pattern as the Rj states, with `mem_sel`=1 and COEFF_COUNT words.
  - After the last coefficient write, go to WAIT_DATA.
- WAIT_DATA (5):
  - `data_ptr`=0.
  - An accepted word is written to data address 0, triggers `compute_start`, and moves to WORKING.
- WORKING (6):
  - Each accepted word advances `data_ptr` (mod DATA_DEPTH), is written at the new `data_ptr`, and triggers `compute_start`.
  - If `compute_busy`=1 when a word is accepted, set `overrun`. It is cleared only by reset or `start`.
- CLEARING (7):
  - Clear sweep of the data memory, identical to INIT. Rj and coefficient memories are retained.
  - Then `data_ptr`=0 and go to WAIT_DATA.
- SLEEPING (8), `sleep`=1:
  - All-zero words are discarded: no write, no compute.
  - The first word with any nonzero bit is handled as in WORKING (pointer advance, write, `compute_start`) and moves the FSM to WORKING.

Zero counter:
- Increments on each accepted word with `word_L`=0 and `word_R`=0; saturates at SLEEP_COUNT.
- Any nonzero accepted word resets it to 0.
- In WORKING, when the counter reaches SLEEP_COUNT, go to SLEEPING after the current word's write and compute.

Priority and boundary cases:
- `start` in any state: go to INIT; clears counters, `data_ptr` and `overrun`. `start` wins over every other event.
- `clear_req` is honored in WAIT_DATA, WORKING and SLEEPING, and ignored in all other states.
- `clear_req` coincident with `word_valid`: clear wins and the word is dropped.
- `in_ready`=0 in INIT and CLEARING; `in_ready`=1 in every other state.
- `data_ptr` wraps DATA_DEPTH-1 → 0.

## Timing
- Reset (asynchronous assert):
  - `state`=INIT, sweep address 0.
  - All outputs 0 except `state`.
  - All counters 0 and `overrun`=0.
- On reset release, the INIT sweep starts on the first `sclk` edge.
- All outputs are registered.
- Accepted word at edge t:
  - `mem_we`, `mem_sel`, `mem_addr` valid for exactly one cycle after edge t+1.
  - `compute_start` high for one cycle after edge t+2.
- Clear sweep: DATA_DEPTH cycles of `mem_we`=1 and `mem_clr`=1. The next state is entered on the following edge.
- The state change on the final load word takes effect on the same edge that registers its write.

## Configuration
Macro `MSDAP_SLEEP_EN`.
- Defined: zero counter and SLEEPING state are present, as described above.
- Undefined:
  - No zero counter, so zero words are always processed.
  - SLEEPING is unreachable and `sleep` is tied to 0.

## Test plan
- Reset, then 16 Rj words and 512 coefficient words: `mem_we` pulses reach Rj address 15 then coeff address 511, and `state` ends at 5; 256 clear cycles are observed before WAIT_RJ.
- 300 samples in WORKING: `data_ptr` wraps 255→0 at sample 257, and each sample yields exactly one `compute_start` two cycles after `word_valid`.
- `clear_req` mid-WORKING, with `word_valid` on the same cycle: the word is not written, 256 clear cycles follow, then WAIT_DATA with `data_ptr`=0; Rj and coeff memories are untouched.
- 800 zero samples: `sleep`=1 after the 800th; a further 10 zero samples produce no `mem_we`; sample 0x0001/0x0000 writes, pulses `compute_start`, and returns the FSM to WORKING. With the macro undefined, all 810 samples are processed and `sleep` stays 0.
- `word_valid` while `compute_busy`=1: `overrun`=1 and stays set; a `start` pulse clears it and returns to INIT.
- `reset` asserted mid-READ_COEFF: all outputs are 0 asynchronously, and the controller restarts at INIT.
